// File: rtl/rgmii_rx_frame.sv
// Ethernet receive framer behind the RGMII DDR demux: strips preamble/SFD, checks FCS,
// and streams payload bytes with sof/eof/err/len at a fixed 6-cycle latency.
module rgmii_rx_frame #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1514
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic [1:0]  rx_ctl,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_sof,
    output logic        m_eof,
    output logic        m_err,
    output logic [13:0] m_len,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_RES   = 32'hDEBB20E3;
    localparam logic [15:0] FCS_BYTES = 16'd4;
    localparam logic [15:0] DLY_BYTES = 16'd5;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    state_t          state;
    logic [4:0][7:0] dline;
    logic [31:0]     crc;
    logic [15:0]     cnt;
    logic            sticky_er;
    logic            rx_dv;
    logic            rx_er;
    logic [15:0]     plen;
    logic            frame_err;

    assign rx_dv = rx_ctl[0];
    assign rx_er = rx_ctl[0] ^ rx_ctl[1];
    assign plen  = cnt - FCS_BYTES;
    assign frame_err = (crc != CRC_RES) || sticky_er ||
                       (plen < 16'(MIN_LEN)) || (plen > 16'(MAX_LEN));

    // Reflected CRC-32, one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_IDLE;
            dline      <= '0;
            crc        <= '0;
            cnt        <= '0;
            sticky_er  <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_sof      <= 1'b0;
            m_eof      <= 1'b0;
            m_err      <= 1'b0;
            m_len      <= '0;
            frames_ok  <= '0;
            frames_bad <= '0;
        end else begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            m_err   <= 1'b0;
            m_len   <= '0;
            case (state)
                WAIT_IDLE: begin
                    if (!rx_dv) state <= IDLE;
                end
                IDLE: begin
                    if (rx_dv) begin
                        if (rx_er) begin
                            state <= DROP;
                        end else if (rx_data == PRE_BYTE) begin
                            state <= PREAMBLE;
                        end else if (rx_data == SFD_BYTE) begin
                            state     <= DATA;
                            crc       <= 32'hFFFFFFFF;
                            cnt       <= '0;
                            sticky_er <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!rx_dv) begin
                        state      <= IDLE;
                        frames_bad <= sat_inc(frames_bad);
                    end else if (rx_er || (rx_data != PRE_BYTE && rx_data != SFD_BYTE)) begin
                        state      <= DROP;
                        frames_bad <= sat_inc(frames_bad);
                    end else if (rx_data == SFD_BYTE) begin
                        state     <= DATA;
                        crc       <= 32'hFFFFFFFF;
                        cnt       <= '0;
                        sticky_er <= 1'b0;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        // Oldest byte leaves only once 5 younger bytes exist, hiding the FCS
                        dline <= {dline[3:0], rx_data};
                        crc   <= crc_byte(crc, rx_data);
                        cnt   <= sat_inc(cnt);
                        if (rx_er) sticky_er <= 1'b1;
                        if (cnt >= DLY_BYTES) begin
                            m_valid <= 1'b1;
                            m_data  <= dline[4];
                            m_sof   <= (cnt == DLY_BYTES);
                        end
                    end else begin
                        state <= IDLE;
                        if (cnt >= DLY_BYTES) begin
                            m_valid <= 1'b1;
                            m_data  <= dline[4];
                            m_sof   <= (cnt == DLY_BYTES);
                            m_eof   <= 1'b1;
                            m_err   <= frame_err;
                            m_len   <= (plen > 16'd16383) ? 14'h3FFF : plen[13:0];
                            if (frame_err) frames_bad <= sat_inc(frames_bad);
                            else           frames_ok  <= sat_inc(frames_ok);
                        end else begin
                            frames_bad <= sat_inc(frames_bad);
                        end
                    end
                end
                DROP: begin
                    if (!rx_dv) state <= IDLE;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule
